// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-stage control and PC/RAS observation bundle for pc_unit
interface pc_unit_if #(parameter int PC_W = 32);
  logic            pcEN;
  logic            halt;
  logic [1:0]      pc_src;
  logic [PC_W-1:0] imm16;
  logic [25:0]     imm26;
  logic [PC_W-1:0] regval;
  logic            ras_push;
  logic            ras_pop;
  logic [PC_W-1:0] imemaddr;
  logic [PC_W-1:0] npc;
  logic            halted;
  logic [PC_W-1:0] ras_top;
  logic            ras_valid;
  modport master (output pcEN, halt, pc_src, imm16, imm26, regval, ras_push, ras_pop,
                  input imemaddr, npc, halted, ras_top, ras_valid);
  modport slave (input pcEN, halt, pc_src, imm16, imm26, regval, ras_push, ras_pop,
                 output imemaddr, npc, halted, ras_top, ras_valid);
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch PC with stall, sticky halt and optional return-address stack (PC_RAS_EN)
module pc_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              RAS_D    = 4
) (
  input logic       CLK,
  input logic       RST,
  pc_unit_if.slave  bus
);
  localparam logic [PC_W-1:0] HI = ~PC_W'(28'hFFFFFFF);
  logic [PC_W-1:0] pc, npc, nxt;
  logic            halted, adv;
  assign npc          = pc + PC_W'(4);
  assign adv          = bus.pcEN && !halted && !bus.halt;
  assign bus.imemaddr = pc;
  assign bus.npc      = npc;
  assign bus.halted   = halted;
  always_comb begin
    nxt = bus.pc_src == 2'b00 ? npc :
          bus.pc_src == 2'b01 ? npc + (bus.imm16 << 2) :
          bus.pc_src == 2'b10 ? (npc & HI) | PC_W'({bus.imm26, 2'b00}) :
          bus.regval;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      if (bus.halt) halted <= 1'b1;
      if (adv) pc <= nxt;
    end
  end
`ifdef PC_RAS_EN
  localparam int AW = $clog2(RAS_D);
  localparam logic [AW:0] FULL = (AW+1)'(RAS_D);
  logic [PC_W-1:0] ent [RAS_D];
  logic [AW-1:0]   ptr;
  logic [AW:0]     cnt;
  assign bus.ras_top   = ent[ptr];
  assign bus.ras_valid = cnt != '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < RAS_D; i++) ent[i] <= '0;
    end else if (adv) begin
      if (bus.ras_push && (!bus.ras_pop || cnt == '0)) begin
        ptr                <= ptr + 1'b1;
        ent[ptr + 1'b1]    <= npc;
        cnt                <= cnt == FULL ? cnt : cnt + 1'b1;
      end else if (bus.ras_push) begin
        ent[ptr] <= npc;
      end else if (bus.ras_pop && cnt != '0) begin
        ptr <= ptr - 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end
`else
  logic unused_ras;
  assign unused_ras    = bus.ras_push ^ bus.ras_pop;
  assign bus.ras_top   = '0;
  assign bus.ras_valid = 1'b0;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit (RAS checks follow PC_RAS_EN)
module tb_pc_unit;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;
  pc_unit_if #(.PC_W(32)) bus ();
  pc_unit #(.PC_W(32), .RESET_PC(32'h0), .RAS_D(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        h;
    logic [31:0] top;
    logic        valid;
  } exp_t;
  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc;
  logic        m_h;
  logic [31:0] r_ent[4];
  int          r_ptr, r_cnt;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask
  task automatic model_reset();
    m_pc = 32'h0;
    m_h = 1'b0;
    r_ptr = 0;
    r_cnt = 0;
    for (int i = 0; i < 4; i++) r_ent[i] = 32'h0;
  endtask
  task automatic do_reset(input string tag);
    RST = 1'b1;
    bus.pcEN = 0; bus.halt = 0; bus.pc_src = 0; bus.imm16 = 0; bus.imm26 = 0;
    bus.regval = 0; bus.ras_push = 0; bus.ras_pop = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    chk({tag, "_pc"}, bus.imemaddr, 32'h0);
    chk({tag, "_npc"}, bus.npc, 32'h4);
    chk({tag, "_halted"}, {31'b0, bus.halted}, 32'h0);
    chk({tag, "_top"}, bus.ras_top, 32'h0);
    chk({tag, "_valid"}, {31'b0, bus.ras_valid}, 32'h0);
  endtask
  task automatic step(input string tag, input bit en, input bit hl, input logic [1:0] src,
                      input logic [31:0] v, input bit push, input bit pop);
    logic [31:0] n, nx;
    bit adv;
    exp_t e;
    bus.pcEN = en; bus.halt = hl; bus.pc_src = src; bus.imm16 = v; bus.imm26 = v[25:0];
    bus.regval = v; bus.ras_push = push; bus.ras_pop = pop;
    #1;
    chk({tag, "_npc"}, bus.npc, m_pc + 32'h4);
    n = m_pc + 32'h4;
    case (src)
      2'b00: nx = n;
      2'b01: nx = n + {v[29:0], 2'b00};
      2'b10: nx = {n[31:28], v[25:0], 2'b00};
      default: nx = v;
    endcase
    adv = en && !m_h && !hl;
`ifdef PC_RAS_EN
    if (adv) begin
      if (push && (!pop || r_cnt == 0)) begin
        r_ptr = (r_ptr + 1) % 4;
        r_ent[r_ptr] = n;
        if (r_cnt < 4) r_cnt++;
      end else if (push) begin
        r_ent[r_ptr] = n;
      end else if (pop && r_cnt != 0) begin
        r_ptr = (r_ptr + 3) % 4;
        r_cnt--;
      end
    end
`endif
    if (adv) m_pc = nx;
    if (hl) m_h = 1'b1;
    q.push_back('{tag, m_pc, m_h, r_ent[r_ptr], r_cnt != 0});
    @(posedge CLK); #1;
    e = q.pop_front();
    chk({e.tag, "_pc"}, bus.imemaddr, e.pc);
    chk({e.tag, "_halted"}, {31'b0, bus.halted}, {31'b0, e.h});
    chk({e.tag, "_top"}, bus.ras_top, e.top);
    chk({e.tag, "_valid"}, {31'b0, bus.ras_valid}, {31'b0, e.valid});
  endtask
  initial begin
    do_reset("rst0");
    step("seq1", 1, 0, 2'b00, 0, 0, 0);
    step("seq2", 1, 0, 2'b00, 0, 0, 0);
    step("seq3", 1, 0, 2'b00, 0, 0, 0);
    chk("seq_c", bus.imemaddr, 32'hC);
    do_reset("rst_mid");
    step("to100", 1, 0, 2'b11, 32'h100, 0, 0);
    step("branch", 1, 0, 2'b01, 32'hFFFFFFFE, 0, 0);
    chk("branch_fc", bus.imemaddr, 32'hFC);
    step("toF", 1, 0, 2'b11, 32'hF0000010, 0, 0);
    step("jump", 1, 0, 2'b10, 32'h40, 0, 0);
    chk("jump_abs", bus.imemaddr, 32'hF0000100);
    step("stall", 0, 0, 2'b11, 32'h2000, 0, 0);
    step("jr", 1, 0, 2'b11, 32'h2000, 0, 0);
    chk("jr_abs", bus.imemaddr, 32'h2000);
    step("to40", 1, 0, 2'b11, 32'h40, 0, 0);
    step("halt", 1, 1, 2'b00, 0, 0, 0);
    step("halted1", 1, 0, 2'b00, 0, 1, 0);
    step("halted2", 1, 0, 2'b11, 32'h80, 0, 0);
    chk("halt_abs", bus.imemaddr, 32'h40);
    do_reset("rst_halt");
    for (int i = 0; i < 5; i++) step($sformatf("push%0d", i), 1, 0, 2'b00, 0, 1, 0);
    for (int i = 0; i < 5; i++) step($sformatf("pop%0d", i), 1, 0, 2'b00, 0, 0, 1);
    step("stall_push", 0, 0, 2'b00, 0, 1, 0);
    do_reset("rst_ras");
    step("to4", 1, 0, 2'b11, 32'h4, 0, 0);
    step("push8", 1, 0, 2'b11, 32'h20, 1, 0);
    step("pushpop", 1, 0, 2'b00, 0, 1, 1);
    step("pop_last", 1, 0, 2'b00, 0, 0, 1);
    step("pop_empty", 1, 0, 2'b00, 0, 0, 1);
    step("pp_empty", 1, 0, 2'b00, 0, 1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
